acq_trigger_controller: RTL and testbench
=========================================

# acq_trigger_controller

Sequences one oscilloscope capture around the single-cycle `triggered` pulse of the trigger detector. It generates write enables and circular addresses for the sample buffer. It splits the buffer into a programmable pre-trigger and post-trigger region and supports normal, auto and single-shot trigger modes. It sits between the host register interface (start, stop, ack) and the capture datapath (detector plus sample RAM).

## Interface
- `ADDR_W`, 10, buffer address width; depth = 2^ADDR_W samples
- `TMO_W`, 16, width of the auto-trigger timeout counter
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse, arm a capture
- `stop`  in  1  one-cycle pulse, abort a capture
- `mode`  in  2  0 normal, 1 auto, 2 single, 3 treated as single
- `pretrig`  in  ADDR_W  number of samples kept before the trigger
- `auto_timeout`  in  TMO_W  clock cycles in ARMED before a forced trigger
- `sample_valid`  in  1  new sample is present this cycle
- `trigger_in`  in  1  detector pulse, aligned with `sample_valid`
- `ack`  in  1  one-cycle pulse, host has read the buffer
- `wr_en`  out  1  write current sample to RAM
- `wr_addr`  out  ADDR_W  RAM write address
- `trig_addr`  out  ADDR_W  address of the trigger sample
- `busy`  out  1  capture in progress (PRE_FILL, ARMED, POST)
- `done`  out  1  buffer full and valid, held until `ack` or `stop`
- `forced`  out  1  last capture was triggered by timeout

## Operation
- States: IDLE, PRE_FILL, ARMED, POST, DONE.
- IDLE -> PRE_FILL on `start`, or directly to ARMED if latched `pretrig` == 0.
  - `pretrig`, `mode` and `auto_timeout` are latched at `start`.
  - `wr_addr` keeps its current value; the pre counter and the timeout counter clear.
- PRE_FILL: each `sample_valid` writes and increments the pre counter. Move to ARMED when the count reaches `pretrig`. `trigger_in` is ignored in this state.
- ARMED: each `sample_valid` writes; the buffer keeps overwriting circularly.
  - `trigger_in` with `sample_valid` sets `trig_addr` to that sample's address. That sample is written, the post counter loads depth − `pretrig` − 1, and the state moves to POST.
  - Auto mode: the timeout counter increments every clock. At `auto_timeout` it forces the same transition on the next `sample_valid` and sets `forced`.
- POST: each `sample_valid` writes and decrements the post counter. On reaching 0 (after that write), move to DONE. If `pretrig` == depth − 1, go straight from the trigger to DONE.
- DONE: `wr_en` = 0 and `done` = 1. On `ack`: single mode goes to IDLE; normal and auto modes re-arm as if `start` had been pulsed.
- `stop` in any state -> IDLE, clearing `done` and `busy`; `trig_addr` is held.
- `start` outside IDLE is ignored. `stop` and `start` in the same cycle: `stop` wins.
- `wr_addr` wraps modulo 2^ADDR_W. The oldest valid sample is at `trig_addr` − `pretrig` (mod depth).
- `forced` clears on the next `start` or re-arm.

## Timing
- Reset values: state IDLE, `wr_en` 0, `wr_addr` 0, `trig_addr` 0, `busy` 0, `done` 0, `forced` 0.
- All outputs are registered.
  - `wr_en`/`wr_addr` appear one clock after the `sample_valid` that caused them. The sample datapath carries a matching one-stage delay.
  - `wr_addr` increments in the cycle after each `wr_en`.
- `done` rises one clock after the final POST write.
- From `ack` to `busy` re-asserting (normal/auto mode): 1 clock.
- Reset mid-capture aborts immediately; no partial `done`.

## Configuration
- `ACQ_AUTO_TRIGGER_EN` defined: auto mode, the timeout counter and `forced` are implemented.
- Undefined:
  - mode 1 behaves as normal mode.
  - `auto_timeout` is ignored.
  - `forced` is tied to 0.
  - The timeout counter is not instantiated.

## Structure
- Shared package `acq_pkg`: state encoding constants and mode codes (MODE_NORMAL, MODE_AUTO, MODE_SINGLE).
- Sub-module `acq_timeout_counter`: TMO_W-bit counter with clear and enable, plus an expiry flag. It is instantiated only under `ACQ_AUTO_TRIGGER_EN`.

## Test plan
All scenarios use ADDR_W=4 (depth 16) and a `sample_valid` every clock.
- Normal capture, `pretrig`=4, trigger on the 10th sample after `start` -> `trig_addr` = start addr + 9; exactly 16 + 5 writes before `done`; `done` rises 12 samples after the trigger.
- `pretrig`=0, trigger on the first sample -> PRE_FILL skipped; 16 writes; `trig_addr` = start addr.
- `pretrig`=15 -> DONE one clock after the trigger write; no POST writes.
- Auto mode, `auto_timeout`=20, no trigger -> forced trigger at clock 21; `forced`=1, `done` follows 16 − `pretrig` samples later.
- Single mode `ack` -> IDLE with `busy`=0. Normal mode `ack` -> `busy`=1 on the next clock and `wr_addr` continues without reset.
- `stop` in POST, and `start`+`stop` in the same cycle in IDLE -> IDLE, `done`=0, no further `wr_en`.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition trigger controller: state encoding,
// trigger mode codes and the mode normalisation helper.
// Optional feature macro: ACQ_AUTO_TRIGGER_EN (auto-trigger mode).
package acq_pkg;

  // Capture sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_DONE     = 3'd4
  } acq_state_e;

  // Trigger mode codes as seen on the host mode field
  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  // Map the raw host mode field onto the modes this build supports.
  // Code 3 is treated as single shot; without the auto-trigger feature
  // the auto code falls back to normal triggering.
  function automatic logic [1:0] acq_norm_mode(input logic [1:0] mode_raw);
    logic [1:0] mode_eff;
    case (mode_raw)
      MODE_NORMAL: mode_eff = MODE_NORMAL;
`ifdef ACQ_AUTO_TRIGGER_EN
      MODE_AUTO:   mode_eff = MODE_AUTO;
`else
      MODE_AUTO:   mode_eff = MODE_NORMAL;
`endif
      default:     mode_eff = MODE_SINGLE;
    endcase
    return mode_eff;
  endfunction

endpackage

// File: rtl/acq_timeout_counter.sv
// Auto-trigger timeout counter: counts enabled clocks from a clear, stops at
// the programmed limit and flags expiry while the count equals the limit.
// Only instantiated when ACQ_AUTO_TRIGGER_EN is defined.
module acq_timeout_counter #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expired_o
);

  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // The count saturates at the limit so the expiry flag stays up until cleared
  assign expired_o = (cnt_q == limit_i);

  // Next count: clear has priority, otherwise count while enabled and not expired
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = TMO_ZERO;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TMO_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= TMO_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acq_trigger_controller.sv
// Oscilloscope capture sequencer. Generates RAM write enables and circular
// write addresses around the trigger detector pulse, splitting the buffer
// into a programmable pre-trigger region and the remaining post-trigger
// region. Supports normal, auto and single-shot trigger modes.
// Optional feature macro: ACQ_AUTO_TRIGGER_EN (auto mode, timeout counter,
// forced flag). Without it mode 1 behaves as normal and forced reads 0.
module acq_trigger_controller
  import acq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [TMO_W-1:0]  auto_timeout,
  input  logic              sample_valid,
  input  logic              trigger_in,
  input  logic              ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              forced
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ALL1 = {ADDR_W{1'b1}};

  acq_state_e        state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] pre_cnt_q;
  logic [ADDR_W-1:0] post_cnt_q;
  logic [ADDR_W-1:0] pretrig_q;
  logic [1:0]        mode_q;

  logic              arm_s;
  logic              expired_s;
  logic [ADDR_W-1:0] cur_addr_s;

  // wr_addr_q only advances the cycle after a write, so a sample arriving
  // while the previous write is still on the bus lands one address further.
  assign cur_addr_s = wr_addr_q + {{(ADDR_W-1){1'b0}}, wr_en_q};

  // Arm a capture on start from IDLE, or re-arm on ack in DONE for the
  // repeating modes; stop always wins.
  always_comb begin
    arm_s = 1'b0;
    if (stop) begin
      arm_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      arm_s = start;
    end else if (state_q == ST_DONE) begin
      arm_s = ack && (mode_q != MODE_SINGLE);
    end else begin
      arm_s = 1'b0;
    end
  end

`ifdef ACQ_AUTO_TRIGGER_EN
  logic [TMO_W-1:0] tmo_q;
  logic             forced_q;
  logic             tmo_expired_s;
  logic             tmo_en_s;

  assign tmo_en_s = (state_q == ST_ARMED) && (mode_q == MODE_AUTO);

  acq_timeout_counter #(
    .TMO_W (TMO_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (arm_s),
    .en_i      (tmo_en_s),
    .limit_i   (tmo_q),
    .expired_o (tmo_expired_s)
  );

  // The counter idles at zero outside auto mode, so qualify with the mode
  // to keep a zero timeout from firing in normal or single captures.
  assign expired_s = tmo_expired_s && (mode_q == MODE_AUTO);
  assign forced    = forced_q;
`else
  logic unused_tmo_s;

  assign unused_tmo_s = ^auto_timeout;
  assign expired_s    = 1'b0;
  assign forced       = 1'b0;
`endif

  // Capture sequencer with registered write strobe, addresses and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= ADDR_ZERO;
      trig_addr_q <= ADDR_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pre_cnt_q   <= ADDR_ZERO;
      post_cnt_q  <= ADDR_ZERO;
      pretrig_q   <= ADDR_ZERO;
      mode_q      <= MODE_NORMAL;
`ifdef ACQ_AUTO_TRIGGER_EN
      tmo_q       <= {TMO_W{1'b0}};
      forced_q    <= 1'b0;
`endif
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= wr_addr_q + {{(ADDR_W-1){1'b0}}, wr_en_q};
      if (stop) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (arm_s) begin
        pretrig_q <= pretrig;
        mode_q    <= acq_norm_mode(mode);
        pre_cnt_q <= ADDR_ZERO;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
`ifdef ACQ_AUTO_TRIGGER_EN
        tmo_q     <= auto_timeout;
        forced_q  <= 1'b0;
`endif
        if (pretrig == ADDR_ZERO) begin
          state_q <= ST_ARMED;
        end else begin
          state_q <= ST_PRE_FILL;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_PRE_FILL: begin
            if (sample_valid) begin
              wr_en_q   <= 1'b1;
              pre_cnt_q <= pre_cnt_q + ADDR_ONE;
              if ((pre_cnt_q + ADDR_ONE) == pretrig_q) begin
                state_q <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            if (sample_valid) begin
              wr_en_q <= 1'b1;
              if (trigger_in || expired_s) begin
                trig_addr_q <= cur_addr_s;
                post_cnt_q  <= ~pretrig_q;
`ifdef ACQ_AUTO_TRIGGER_EN
                forced_q    <= !trigger_in;
`endif
                if (pretrig_q == ADDR_ALL1) begin
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (sample_valid) begin
              wr_en_q    <= 1'b1;
              post_cnt_q <= post_cnt_q - ADDR_ONE;
              if (post_cnt_q == ADDR_ONE) begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            // done follows the last write by one clock; busy hands over to it
            busy_q <= 1'b0;
            if (ack) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
            end else begin
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign trig_addr = trig_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_acq_trigger_controller.sv
// Directed self-checking bench for acq_trigger_controller (ADDR_W=4, depth 16,
// sample_valid every clock). Inputs change and outputs are sampled on the
// falling edge. Adapts the auto-mode scenario to ACQ_AUTO_TRIGGER_EN.
module tb_acq_trigger_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [3:0]  pretrig;
  logic [15:0] auto_timeout;
  logic        sample_valid;
  logic        trigger_in;
  logic        ack;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  trig_addr;
  logic        busy;
  logic        done;
  logic        forced;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int exp_addr = 0;

  acq_trigger_controller #(
    .ADDR_W (4),
    .TMO_W  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .pretrig      (pretrig),
    .auto_timeout (auto_timeout),
    .sample_valid (sample_valid),
    .trigger_in   (trigger_in),
    .ack          (ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .trig_addr    (trig_addr),
    .busy         (busy),
    .done         (done),
    .forced       (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs were applied on the falling edge, sample on the next one
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (wr_en) wr_cnt++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; pretrig = 4'd0;
    auto_timeout = 16'd20; sample_valid = 1'b0; trigger_in = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_trig_addr", 32'(trig_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_forced", 32'(forced), 32'd0);
    reset = 1'b0;
    sample_valid = 1'b1;
    tick();
    check_eq("idle_no_write", 32'(wr_en), 32'd0);

    // ---- Normal capture, pretrig 4, trigger on 10th sample ----
    mode = 2'd0; pretrig = 4'd4;
    start = 1'b1; tick(); start = 1'b0; wr_cnt = 0;
    check_eq("s1_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 22; k++) begin
      trigger_in = (k == 10);
      tick();
      if (k == 10) begin
        check_eq("s1_trig_addr", 32'(trig_addr), 32'd9);
        check_eq("s1_trig_wr_addr", 32'(wr_addr), 32'd9);
      end
      if (k == 21) begin
        check_eq("s1_done_early", 32'(done), 32'd0);
        check_eq("s1_busy_late", 32'(busy), 32'd1);
      end
    end
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_busy_off", 32'(busy), 32'd0);
    check_eq("s1_wr_en_off", 32'(wr_en), 32'd0);
    check_eq("s1_writes", 32'(wr_cnt), 32'd21);
    exp_addr = (exp_addr + 21) % 16;
    check_eq("s1_wr_addr_oldest", 32'(wr_addr), 32'(exp_addr));
    // Normal-mode ack re-arms next clock without resetting the address
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("s1_rearm_busy", 32'(busy), 32'd1);
    check_eq("s1_rearm_done", 32'(done), 32'd0);
    tick();
    check_eq("s1_rearm_wr_en", 32'(wr_en), 32'd1);
    check_eq("s1_rearm_wr_addr", 32'(wr_addr), 32'(exp_addr));
    stop = 1'b1; tick(); stop = 1'b0;
    exp_addr = (exp_addr + 1) % 16;
    check_eq("s1_stop_busy", 32'(busy), 32'd0);
    check_eq("s1_stop_wr_en", 32'(wr_en), 32'd0);
    check_eq("s1_stop_wr_addr", 32'(wr_addr), 32'(exp_addr));

    // ---- pretrig 0, trigger on first sample, single mode ----
    mode = 2'd2; pretrig = 4'd0;
    start = 1'b1; tick(); start = 1'b0; wr_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      trigger_in = (k == 1);
      tick();
      if (k == 1) check_eq("s2_trig_addr", 32'(trig_addr), 32'(exp_addr));
      if (k == 16) check_eq("s2_done_early", 32'(done), 32'd0);
    end
    check_eq("s2_done", 32'(done), 32'd1);
    check_eq("s2_writes", 32'(wr_cnt), 32'd16);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("s2_ack_busy", 32'(busy), 32'd0);
    check_eq("s2_ack_done", 32'(done), 32'd0);
    tick(); tick();
    check_eq("s2_idle_writes", 32'(wr_cnt), 32'd16);
    check_eq("s2_idle_busy", 32'(busy), 32'd0);

    // ---- pretrig 15 (mode 3 = single), trigger in pre-fill ignored ----
    mode = 2'd3; pretrig = 4'd15;
    start = 1'b1; tick(); start = 1'b0; wr_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      trigger_in = (k == 3) || (k == 16);
      tick();
      if (k == 16) begin
        check_eq("s3_trig_addr", 32'(trig_addr), 32'((exp_addr + 15) % 16));
        check_eq("s3_done_early", 32'(done), 32'd0);
      end
    end
    check_eq("s3_done", 32'(done), 32'd1);
    check_eq("s3_writes", 32'(wr_cnt), 32'd16);
    check_eq("s3_wr_en_off", 32'(wr_en), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("s3_ack_busy", 32'(busy), 32'd0);

    // ---- Auto mode, timeout 20, no trigger ----
    mode = 2'd1; pretrig = 4'd0; auto_timeout = 16'd20; trigger_in = 1'b0;
    start = 1'b1; tick(); start = 1'b0; wr_cnt = 0;
`ifdef ACQ_AUTO_TRIGGER_EN
    for (int k = 1; k <= 37; k++) begin
      tick();
      if (k == 20) check_eq("s4_forced_early", 32'(forced), 32'd0);
      if (k == 21) begin
        check_eq("s4_forced", 32'(forced), 32'd1);
        check_eq("s4_trig_addr", 32'(trig_addr), 32'((exp_addr + 20) % 16));
      end
      if (k == 36) check_eq("s4_done_early", 32'(done), 32'd0);
    end
    check_eq("s4_done", 32'(done), 32'd1);
    check_eq("s4_writes", 32'(wr_cnt), 32'd36);
    exp_addr = (exp_addr + 36) % 16;
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("s4_rearm_forced", 32'(forced), 32'd0);
    check_eq("s4_rearm_busy", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
`else
    for (int k = 1; k <= 37; k++) begin
      tick();
      if (k == 21) check_eq("s4_no_force_trig", 32'(trig_addr), 32'((exp_addr + 15) % 16));
    end
    check_eq("s4_no_done", 32'(done), 32'd0);
    check_eq("s4_still_busy", 32'(busy), 32'd1);
    check_eq("s4_forced_tied", 32'(forced), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    exp_addr = (exp_addr + 37) % 16;
`endif
    check_eq("s4_wr_addr", 32'(wr_addr), 32'(exp_addr));

    // ---- stop during POST ----
    mode = 2'd0; pretrig = 4'd0;
    start = 1'b1; tick(); start = 1'b0; wr_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      trigger_in = (k == 1);
      tick();
    end
    trigger_in = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("s5_stop_busy", 32'(busy), 32'd0);
    check_eq("s5_stop_wr_en", 32'(wr_en), 32'd0);
    check_eq("s5_trig_held", 32'(trig_addr), 32'(exp_addr));
    repeat (20) tick();
    check_eq("s5_no_writes", 32'(wr_cnt), 32'd3);
    check_eq("s5_no_done", 32'(done), 32'd0);

    // ---- start and stop together in IDLE ----
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("s6_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check_eq("s6_no_writes", 32'(wr_cnt), 32'd3);

    // ---- reset mid-capture ----
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    check_eq("s7_rst_busy", 32'(busy), 32'd0);
    check_eq("s7_rst_wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("s7_rst_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
